// File: rtl/cic_sample_fifo.sv
// cic_sample_fifo
//   Post-processing stage for the CIC decimator output. Each decimated sample
//   passes through the following steps:
//     1. The DC offset is removed.
//     2. An arithmetic right shift is applied.
//     3. The result is saturated to signed OUT_W.
//     4. The result is queued in a first-word-fall-through FIFO.
//   The consumer drains the FIFO with a valid/ready handshake.
//
// Ports
//   clk, rst   clock; synchronous active-high reset
//   in_data    CIC sample (unsigned), qualified by the in_rdy one-cycle strobe
//   offset     DC offset, sampled with the strobe
//   shift      right-shift amount 0..31, sampled with the strobe
//   out_data   head-of-FIFO sample (signed); 0 while empty
//   out_valid  FIFO non-empty
//   out_ready  consumer pops the head when out_valid=1
//   level      FIFO occupancy 0..DEPTH
//   sat        one-cycle pulse: the stage-2 sample was clamped
//   overflow   sticky: a sample was dropped on a full FIFO; cleared by ovf_clr
module cic_sample_fifo #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_rdy,
  input  logic [IN_W-1:0]  offset,
  input  logic [4:0]       shift,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic             sat,
  output logic             overflow,
  input  logic             ovf_clr
);

  // ---------------- stage 1: offset removal, capture shift ----------------
  logic                   s1_vld;
  logic signed [IN_W:0]   s1_diff;
  logic [4:0]             s1_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_diff  <= '0;
      s1_shift <= '0;
    end else begin
      s1_vld <= in_rdy;
      if (in_rdy) begin
        // The difference of two zero-extended unsigned values always fits in
        // IN_W+1 bits of two's complement.
        s1_diff  <= $signed({1'b0, in_data} - {1'b0, offset});
        s1_shift <= shift;
      end
    end
  end

  // ---------------- stage 2: shift + saturate (combinational) ------------
  logic signed [IN_W:0]   t;
  logic                   fits;
  logic [OUT_W-1:0]       s2_val;

  always_comb begin
    t    = s1_diff >>> s1_shift;
    // The value fits in OUT_W signed bits iff every bit from the OUT_W sign
    // position upward is a copy of the sign bit.
    fits = (&t[IN_W:OUT_W-1]) | ~(|t[IN_W:OUT_W-1]);
    if (fits)
      s2_val = t[OUT_W-1:0];
    else if (t[IN_W])
      s2_val = {1'b1, {(OUT_W-1){1'b0}}};
    else
      s2_val = {1'b0, {(OUT_W-1){1'b1}}};
  end

  // ---------------- FIFO ----------------
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, rd_en, wr_en, drop;

  assign out_valid = (level != '0);
  assign full      = (level == (AW+1)'(DEPTH));
  assign rd_en     = out_valid & out_ready;
  // When full, a same-edge pop frees the slot being written.
  assign wr_en     = s1_vld & (~full | rd_en);
  assign drop      = s1_vld & full & ~rd_en;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      sat      <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      sat <= s1_vld & ~fits;

      if (wr_en) begin
        mem[wr_ptr] <= s2_val;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;

      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_sample_fifo.sv
module tb_cic_sample_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_rdy;
  logic [31:0] offset;
  logic [4:0]  shift;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        sat;
  logic        overflow;
  logic        ovf_clr;

  cic_sample_fifo #(.IN_W(32), .OUT_W(16), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_rdy(in_rdy),
    .offset(offset), .shift(shift), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .sat(sat), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic in wide signed integers.
  task automatic mdl(input logic [31:0] d, input logic [31:0] o, input logic [4:0] s,
                     output logic [15:0] v, output bit c);
    longint x;
    x = d;
    x = x - o;
    x = x >>> s;
    c = 1'b0;
    if (x > 32767) begin v = 16'h7FFF; c = 1'b1; end
    else if (x < -32768) begin v = 16'h8000; c = 1'b1; end
    else v = x[15:0];
  endtask

  // Scoreboard: expected FIFO contents plus the in-flight stage-1 sample.
  logic [15:0] sb[$];
  bit          p1_vld = 0;
  logic [15:0] p1_val = '0;
  bit          p1_sat = 0;
  bit          msat = 0;
  bit          movf = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          first_pop = -1;
  int          last_pop = -1;
  int          maxlvl = 0;

  // One clock: compare popped head before the edge, advance the model at the
  // edge, then compare every output #1 later.
  task automatic tick();
    bit rd, c, drop;
    logic [15:0] v;
    rd = out_ready && (sb.size() > 0) && !rst;
    if (rd) begin
      chk("pop_data", out_data, sb[0]);
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    mdl(in_data, offset, shift, v, c);
    @(posedge clk);
    cyc++;
    if (rst) begin
      sb.delete(); p1_vld = 0; msat = 0; movf = 0;
    end else begin
      drop = 0;
      if (rd) void'(sb.pop_front());
      msat = p1_vld && p1_sat;
      if (p1_vld) begin
        if (sb.size() < 16) sb.push_back(p1_val);
        else drop = 1;
      end
      if (drop) movf = 1;
      else if (ovf_clr) movf = 0;
      p1_vld = in_rdy; p1_val = v; p1_sat = c;
    end
    #1;
    chk("level", level, sb.size());
    chk("out_valid", out_valid, (sb.size() > 0));
    chk("out_data", out_data, (sb.size() > 0) ? sb[0] : 16'h0);
    chk("sat", sat, msat);
    chk("overflow", overflow, movf);
    if (int'(level) > maxlvl) maxlvl = level;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] off;
    logic [4:0]  sh;
    logic [15:0] exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{32'h0000_1100, 32'h0000_0100, 5'd4,  16'h0100, 1'b0};
    vt[1]  = '{32'h0010_0000, 32'h0,         5'd0,  16'h7FFF, 1'b1};
    vt[2]  = '{32'h0,         32'h0000_0010, 5'd0,  16'hFFF0, 1'b0};
    vt[3]  = '{32'h0,         32'h0001_0000, 5'd0,  16'h8000, 1'b1};
    vt[4]  = '{32'hFFFF_FFFF, 32'h0,         5'd31, 16'h0001, 1'b0};
    vt[5]  = '{32'h0,         32'hFFFF_FFFF, 5'd31, 16'hFFFE, 1'b0};
    vt[6]  = '{32'h0000_8000, 32'h0,         5'd0,  16'h7FFF, 1'b1};
    vt[7]  = '{32'h0000_7FFF, 32'h0,         5'd0,  16'h7FFF, 1'b0};
    vt[8]  = '{32'h0,         32'h0000_8000, 5'd0,  16'h8000, 1'b0};
    vt[9]  = '{32'h0,         32'h0000_8001, 5'd0,  16'h8000, 1'b1};
    vt[10] = '{32'h1234_5678, 32'h0234_5678, 5'd16, 16'h1000, 1'b0};

    rst = 1; in_data = 0; in_rdy = 0; offset = 0; shift = 0;
    out_ready = 0; ovf_clr = 0;
    tick(); tick();
    rst = 0;
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ovf", overflow, 0);

    // ---- table-driven arithmetic vectors ----
    for (int i = 0; i < 11; i++) begin
      in_data = vt[i].din; offset = vt[i].off; shift = vt[i].sh; in_rdy = 1;
      tick();
      chk("vec_latency", out_valid, 0);
      in_rdy = 0;
      offset = $urandom; shift = 5'($urandom_range(0, 31));  // must not affect in-flight data
      tick();
      chk("vec_data", out_data, vt[i].exp_data);
      chk("vec_sat", sat, vt[i].exp_sat);
      chk("vec_level", level, 1);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("vec_sat_pulse", sat, 0);
      chk("vec_empty", out_valid, 0);
    end

    // ---- fill past full: 17 strobes with out_ready low ----
    offset = 0; shift = 0;
    for (int i = 1; i <= 17; i++) begin
      in_data = i; in_rdy = 1;
      tick();
    end
    in_rdy = 0;
    tick();
    chk("full_level", level, 16);
    chk("full_ovf", overflow, 1);
    chk("full_head", out_data, 1);

    // ---- full + stage-2 write of 99 with a same-edge pop ----
    in_data = 99; in_rdy = 1;
    tick();
    in_rdy = 0; out_ready = 1;
    tick();
    out_ready = 0;
    chk("fullrw_level", level, 16);
    chk("fullrw_head", out_data, 2);
    chk("fullrw_ovf", overflow, 1);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("ovf_clr", overflow, 0);

    // drain: 2..16 then 99
    out_ready = 1;
    for (int i = 0; i < 16; i++) tick();
    out_ready = 0;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_data", out_data, 0);
    chk("drain_level", level, 0);

    // ---- continuous streaming ----
    maxlvl = 0; first_pop = -1; n_pop = 0;
    out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      in_data = i; in_rdy = 1;
      tick();
    end
    in_rdy = 0;
    tick(); tick(); tick();
    out_ready = 0;
    chk("stream_count", n_pop, 100);
    chk("stream_nogap", last_pop - first_pop, 99);
    chk("stream_maxlvl", (maxlvl <= 1), 1);

    // ---- reset mid-operation ----
    for (int i = 0; i < 5; i++) begin
      in_data = 10 + i; in_rdy = 1;
      tick();
    end
    in_data = 32'h0010_0000;  // saturating sample left in stage 1
    tick();
    in_rdy = 0;
    chk("pre_rst_level", level, 5);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_level", level, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_sat", sat, 0);
    tick();
    chk("midrst_nowrite", level, 0);
    chk("midrst_nosat", sat, 0);
    in_data = 7; in_rdy = 1;
    tick();
    in_rdy = 0;
    tick();
    chk("post_rst_level", level, 1);
    chk("post_rst_data", out_data, 7);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("post_rst_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cic_sample_fifo.md
Name: cic_sample_fifo

Overview:
- Downstream stage of the CIC decimator, consuming its 32-bit unsigned count output and one-cycle ready strobe.
- Removes a programmable DC offset and applies a programmable arithmetic right shift.
- Saturates the result to signed 16-bit and buffers it in a first-word-fall-through FIFO with a valid/ready output handshake.
- Decouples the bursty decimated sample stream from the slower consumer (correlator / UART / readout logic).

Parameters:
- IN_W, 32, input sample width (CIC output width).
- OUT_W, 16, output sample width, signed two's complement.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- AW, 4, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  IN_W  CIC output sample, unsigned.
- in_rdy  in  1  one-cycle strobe; in_data valid this cycle.
- offset  in  IN_W  DC offset subtracted from in_data, unsigned.
- shift  in  5  arithmetic right-shift amount, 0..31.
- out_data  out  OUT_W  head-of-FIFO sample, signed.
- out_valid  out  1  FIFO non-empty; out_data valid.
- out_ready  in  1  consumer accepts head this cycle when out_valid=1.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- sat  out  1  one-cycle pulse; the sample just written was saturated.
- overflow  out  1  sticky; set when a sample is dropped because the FIFO is full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset values: out_data=0, out_valid=0, level=0, sat=0, overflow=0. Pipeline valid bits, read/write pointers and stored data are all cleared. Reset mid-operation discards all buffered and in-flight samples; no write occurs on the cycle after reset deasserts.
- Stage 1 (edge k where in_rdy=1):
  - s1_diff <= sign-extended 33-bit (in_data - offset).
  - s1_shift <= shift.
  - s1_vld <= 1. s1_vld=0 at any edge where in_rdy=0.
  - offset and shift are sampled only here; later changes do not affect in-flight data.
- Stage 2 (edge k+1 if s1_vld):
  - t = s1_diff >>> s1_shift (arithmetic shift).
  - If t > 32767, write 32767. If t < -32768, write -32768. Otherwise write t[15:0].
  - sat <= 1 for exactly one cycle when clamping occurred; otherwise sat=0.
- Latency: in_rdy sampled at edge k gives out_valid=1 after edge k+1 when the FIFO was previously empty. Throughput is one sample per cycle (back-to-back in_rdy supported).
- Output is FWFT:
  - out_data = mem[rd_ptr] when out_valid=1, else 0.
  - A read occurs at an edge where out_valid=1 and out_ready=1; rd_ptr advances.
  - out_ready while out_valid=0 is ignored.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- Write rules, at an edge with a stage-2 write request:
  - Not full: store, advance wr_ptr.
  - Full and a read in the same edge: store and advance; level stays DEPTH.
  - Full and no read: drop the sample; level, pointers and mem are unchanged; overflow <= 1.
- level: +1 on write only, -1 on read only, unchanged on simultaneous read+write or on no activity.
- Pointers are AW bits wide and wrap modulo DEPTH.
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr forces overflow to 0.
- Sample order is strictly preserved; no sample is duplicated.

Test Plan:
- offset=0x100, shift=4, in_data=0x1100, one in_rdy pulse, out_ready=0 -> out_valid rises 2 edges after the strobe, out_data=0x0100, level=1, sat=0.
- offset=0, shift=0, in_data=0x0010_0000 -> out_data=0x7FFF, sat pulses once. Then in_data=0, offset=0x10 -> out_data=0xFFF0 (-16), sat=0. Then in_data=0, offset=0x0001_0000, shift=0 -> 0x8000, sat=1.
- out_ready=0, 17 strobes with in_data=1..17, offset=0, shift=0 -> level=16, overflow=1 after the 17th. Draining yields 1..16 in order, then out_valid=0, out_data=0, level=0.
- FIFO full and overflow=1; in the same cycle the stage-2 write of value 99 occurs with out_ready=1 -> head popped, 99 stored at the tail, level stays 16, no additional drop. Then ovf_clr=1 with no concurrent drop -> overflow=0.
- Continuous in_rdy every cycle with out_ready=1 for 100 cycles, values 0..99 -> output stream 0..99 with no gaps after the 2-cycle fill, level never exceeds 1.
- 5 samples buffered plus one in stage 1; assert rst for 1 cycle -> level=0, out_valid=0, overflow=0, sat=0. The in-flight sample is never output; the next strobe (value 7) appears as the sole entry.
